// File: rtl/rv_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide units.
package rv_muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } divrem_state_t;

endpackage

// File: rtl/divrem.sv
// Multi-cycle RV32M divide/remainder unit: radix-2 restoring division on
// operand magnitudes, one quotient bit per cycle, with a final sign fix-up.
// Divide-by-zero and signed overflow bypass the iteration entirely.
module divrem
    import rv_muldiv_pkg::*;
#(
    parameter int XLEN  = rv_muldiv_pkg::XLEN,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    input  logic            div,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result,
    output logic            complete,
    output logic            busy
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    divrem_state_t state, state_nxt;

    logic            is_rem, neg_q, neg_r;
    logic [XLEN-1:0] ymag, quot, rem_acc;
    logic [CNT_W-1:0] cnt;

    // Operand decode, only meaningful while IDLE with div high.
    // funct3[2] carries no information for this unit.
    logic            unused_f3_hi;
    logic            op_signed, x_neg, y_neg, div_zero, ovf, special;
    logic [XLEN-1:0] xmag, ymag_in, special_res;

    assign unused_f3_hi = funct3[2];
    assign op_signed    = ~funct3[0];
    assign x_neg        = op_signed & x[XLEN-1];
    assign y_neg        = op_signed & y[XLEN-1];
    // Magnitude of the most negative value wraps to itself, which reads
    // correctly as unsigned 2^(XLEN-1).
    assign xmag         = x_neg ? -x : x;
    assign ymag_in      = y_neg ? -y : y;
    assign div_zero     = (y == '0);
    assign ovf          = op_signed & (x == {1'b1, {(XLEN-1){1'b0}}}) & (&y);
    assign special      = div_zero | ovf;
    // Divide by zero: q = all ones, r = x.  Overflow: q = x (min int), r = 0.
    assign special_res  = div_zero ? (funct3[1] ? x  : '1)
                                   : (funct3[1] ? '0 : x);

    // One restoring step: bring in the next dividend bit and trial-subtract.
    // The partial remainder stays below ymag, so the difference fits XLEN bits.
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] diff;

    assign shifted = {rem_acc, quot[XLEN-1]};
    assign ge      = (shifted >= {1'b0, ymag});
    assign diff    = shifted[XLEN-1:0] - ymag;

    assign complete = (state == DONE);
    assign busy     = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; strobes outside IDLE are dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (div) state_nxt = special ? DONE : CALC;
            CALC: if (cnt == LAST_ITER) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up and result load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_rem  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            ymag    <= '0;
            quot    <= '0;
            rem_acc <= '0;
            cnt     <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: if (div) begin
                    is_rem  <= funct3[1];
                    neg_q   <= x_neg ^ y_neg;
                    neg_r   <= x_neg;
                    ymag    <= ymag_in;
                    quot    <= xmag;
                    rem_acc <= '0;
                    cnt     <= '0;
                    if (special) result <= special_res;
                end
                CALC: begin
                    rem_acc <= ge ? diff : shifted[XLEN-1:0];
                    quot    <= {quot[XLEN-2:0], ge};
                    cnt     <= cnt + 1'b1;
                end
                FIX: begin
                    if (is_rem) result <= neg_r ? -rem_acc : rem_acc;
                    else        result <= neg_q ? -quot    : quot;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divrem.sv
// Self-checking bench for divrem: directed cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_divrem;
    import rv_muldiv_pkg::*;

    localparam int NORM_LAT = 33;  // negedges after the strobe edge until complete

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] x = '0, y = '0;
    logic        div = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] result;
    logic        complete, busy;

    int n_checks = 0;
    int n_fail   = 0;

    divrem dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .div(div), .funct3(funct3),
        .result(result), .complete(complete), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V M-extension semantics written with ordinary integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'h0;
        end else if (!f[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return f[1] ? r : q;
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] exp_res;
        int exp_lat, lat;
        exp_res = ref_model(f, a, b);
        exp_lat = is_fast(f, a, b) ? 0 : NORM_LAT;
        @(negedge clk);
        x = a; y = b; funct3 = f; div = 1'b1;
        @(negedge clk);
        div = 1'b0; x = $urandom; y = $urandom; funct3 = 3'($urandom);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL %s busy_after_strobe: got %b want 1", name, busy);
        end
        lat = 0;
        while (complete !== 1'b1 && lat < 100) begin
            @(negedge clk); lat++;
        end
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (result !== exp_res) begin
            n_fail++; $display("FAIL %s result: f3=%b x=%h y=%h got %h want %h", name, f, a, b, result, exp_res);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL %s busy_in_done: got %b want 1", name, busy);
        end
        @(negedge clk);
        n_checks++;
        if (complete !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL %s after_done: complete=%b busy=%b want 0 0", name, complete, busy);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (result !== 32'h0 || complete !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: result=%h complete=%b busy=%b want 0 0 0", result, complete, busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(F3_DIVU, 32'd100, 32'd7, "divu_100_7");
        run_op(F3_REMU, 32'd100, 32'd7, "remu_100_7");
        run_op(F3_DIV,  32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(F3_REM,  32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run_op(F3_REM,  32'd7, 32'hFFFF_FFFE, "rem_7_m2");
        run_op(F3_DIV,  32'h8000_0000, 32'd1, "div_min_1");
        run_op(F3_DIVU, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    endtask

    task automatic test_special();
        run_op(F3_DIVU, 32'd5, 32'd0, "divu_by_zero");
        run_op(F3_REM,  32'd5, 32'd0, "rem_by_zero");
        run_op(F3_DIV,  32'hFFFF_FFFB, 32'd0, "div_neg_by_zero");
        run_op(F3_REMU, 32'h8000_0000, 32'd0, "remu_by_zero");
        run_op(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        run_op(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
        run_op(F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, "divu_no_overflow");
    endtask

    task automatic test_busy();
        int c;
        @(negedge clk);
        x = 32'd100; y = 32'd7; funct3 = F3_DIVU; div = 1'b1;
        @(negedge clk);
        div = 1'b0;
        c = 0;
        while (complete !== 1'b1 && c < 100) begin
            if (c == 10) begin x = 32'd9; y = 32'd3; funct3 = F3_DIVU; div = 1'b1; end
            else div = 1'b0;
            @(negedge clk); c++;
        end
        div = 1'b0;
        n_checks++;
        if (c !== NORM_LAT) begin
            n_fail++; $display("FAIL busy_drop latency: got %0d want %0d", c, NORM_LAT);
        end
        n_checks++;
        if (result !== 32'd14) begin
            n_fail++; $display("FAIL busy_drop result: got %h want %h", result, 32'd14);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (complete !== 1'b0 || result !== 32'd14) begin
                n_fail++; $display("FAIL busy_hold cycle %0d: complete=%b result=%h want 0 %h", i, complete, result, 32'd14);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clk);
        x = 32'hFFFF_FF9C; y = 32'd7; funct3 = F3_DIV; div = 1'b1;
        @(negedge clk);
        div = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (result !== 32'h0 || busy !== 1'b0 || complete !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: result=%h busy=%b complete=%b want 0 0 0", result, busy, complete);
        end
        pulses = 0;
        repeat (3) begin @(negedge clk); if (complete === 1'b1) pulses++; end
        rst = 1'b1;
        repeat (40) begin @(negedge clk); if (complete === 1'b1) pulses++; end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL reset_mid_no_complete: got %0d pulses want 0", pulses);
        end
        run_op(F3_DIVU, 32'd9, 32'd3, "after_reset_divu_9_3");
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            f = {($urandom_range(0, 7) != 0), 2'($urandom)};
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                1: b = $urandom_range(1, 20);
                2: b = 32'h0;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: a = 32'h8000_0000;
                5: begin a = -$urandom_range(1, 1000); b = -$urandom_range(1, 30); end
                default: ;
            endcase
            run_op(f, a, b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_special();
        test_busy();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
